// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator
//   Serial bit-pattern transmitter. On start it latches a pattern word,
//   length, repeat count and inter-repetition gap, then shifts the pattern
//   out MSB-first (from pattern[L-1]), one bit per clock. Repetitions are
//   separated by `gap` zero bits. Outputs are decoded from registered state.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   start           begin a transfer (sampled in IDLE only)
//   abort           cancel an active transfer (SEND/GAP only), no done pulse
//   pattern         pattern bits, first bit sent is pattern[pat_len-1]
//   pat_len         pattern length; 0 or >PAT_W means PAT_W
//   reps            repetition count; 0 means go straight to DONE
//   gap             zero bits between repetitions
//   data/valid      serial stream and its qualifier
//   last_bit        data is the final bit of a repetition
//   busy            not in IDLE
//   done            one-cycle pulse at normal completion
module seq_pattern_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             data,
  output logic             valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             state, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [LEN_W-1:0]   bit_idx, bit_idx_d;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [LEN_W-1:0]   len_eff;

  // Out-of-range lengths fall back to the full pattern width.
  assign len_eff = ((pat_len == '0) || (pat_len > PAT_W_L)) ? PAT_W_L : pat_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      bit_idx <= bit_idx_d;
      rep_cnt <= rep_cnt_d;
      gap_cnt <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    bit_idx_d = bit_idx;
    rep_cnt_d = rep_cnt;
    gap_cnt_d = gap_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          len_d     = len_eff;
          gap_d     = gap;
          rep_cnt_d = reps;
          bit_idx_d = len_eff - 1'b1;
          state_d   = (reps == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_idx != '0) begin
          bit_idx_d = bit_idx - 1'b1;
        end else if (rep_cnt == REP_W'(1)) begin
          // Final repetition ends here; rep_cnt is never taken below 1.
          state_d = DONE;
        end else begin
          rep_cnt_d = rep_cnt - 1'b1;
          if (gap_q == '0) begin
            bit_idx_d = len_q - 1'b1;   // back-to-back, no bubble
          end else begin
            gap_cnt_d = gap_q - 1'b1;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt == '0) begin
          bit_idx_d = len_q - 1'b1;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    data     = 1'b0;
    valid    = 1'b0;
    last_bit = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (state == SEND) begin
      data     = pat_q[bit_idx[IDX_W-1:0]];
      valid    = 1'b1;
      last_bit = (bit_idx == '0);
    end else if (state == GAP) begin
      valid    = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_generator.sv
module tb_seq_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       data, valid, last_bit, busy, done;

  int checks   = 0;
  int failures = 0;

  seq_pattern_generator #(.PAT_W(8), .LEN_W(4), .REP_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .pat_len(pat_len), .reps(reps), .gap(gap),
    .data(data), .valid(valid), .last_bit(last_bit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // exp = {data, valid, last_bit, busy, done}
  task automatic chk(input string tag, input int cyc, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {data, valid, last_bit, busy, done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%b exp=%b (data,valid,last,busy,done)", tag, cyc, obs, exp);
    end
  endtask

  // Present config with start high for one rising edge (the start edge).
  task automatic kick(input logic [7:0] p, input logic [3:0] l,
                      input logic [7:0] r, input logic [3:0] g);
    @(negedge clk);
    pattern = p; pat_len = l; reps = r; gap = g; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  logic [3:0]  s4;
  logic [10:0] s11;
  logic [7:0]  s8;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; pat_len = '0; reps = '0; gap = '0;
    s4  = 4'b1011;
    s11 = 11'b1011_000_1011;
    s8  = 8'b1010_0101;

    #1 chk("reset_async", 0, 5'b00000);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); chk("idle_after_reset", 0, 5'b00000);

    // 1011 x6, no gap: back-to-back repetitions.
    kick(8'b0000_1011, 4'd4, 8'd6, 4'd0);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      chk("rep6_stream", c, {s4[3 - ((c - 1) % 4)], 1'b1, ((c % 4) == 0), 1'b1, 1'b0});
    end
    @(negedge clk); chk("rep6_done", 25, 5'b00011);
    @(negedge clk); chk("rep6_idle", 26, 5'b00000);

    // 1011 x2 with gap of 3.
    kick(8'b0000_1011, 4'd4, 8'd2, 4'd3);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("gap3_stream", c, {s11[11 - c], 1'b1, (c == 4 || c == 11), 1'b1, 1'b0});
    end
    @(negedge clk); chk("gap3_done", 12, 5'b00011);
    @(negedge clk); chk("gap3_idle", 13, 5'b00000);

    // reps = 0: straight to DONE.
    kick(8'hFF, 4'd4, 8'd0, 4'd2);
    @(negedge clk); chk("reps0_done", 1, 5'b00011);
    @(negedge clk); chk("reps0_idle", 2, 5'b00000);

    // pat_len 0 and 12 both mean 8.
    for (int k = 0; k < 2; k++) begin
      kick(8'hA5, (k == 0) ? 4'd0 : 4'd12, 8'd1, 4'd0);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        chk(k == 0 ? "len0_stream" : "len12_stream", c, {s8[8 - c], 1'b1, (c == 8), 1'b1, 1'b0});
      end
      @(negedge clk); chk(k == 0 ? "len0_done" : "len12_done", 9, 5'b00011);
      @(negedge clk); chk(k == 0 ? "len0_idle" : "len12_idle", 10, 5'b00000);
    end

    // Re-start in cycle 3 (ignored, new config too), abort in cycle 6.
    kick(8'b0000_1011, 4'd4, 8'd6, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 6)
        chk("ctl_stream", c, {s4[3 - ((c - 1) % 4)], 1'b1, ((c % 4) == 0), 1'b1, 1'b0});
      else
        chk("abort_idle", c, 5'b00000);
      start = (c == 3);
      abort = (c == 6);
      if (c == 3) begin pattern = 8'h00; pat_len = 4'd8; reps = 8'd1; end
    end
    abort = 1'b0;

    // Max repeat count, 1-bit pattern: 255 ones, no wrap.
    kick(8'h01, 4'd1, 8'd255, 4'd0);
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk);
      if (c == 1 || c == 128 || c >= 254) chk("max_stream", c, 5'b11110);
    end
    @(negedge clk); chk("max_done", 256, 5'b00011);
    @(negedge clk); chk("max_idle", 257, 5'b00000);

    // Async reset in the middle of a gap, then a fresh run.
    kick(8'b0000_1011, 4'd4, 8'd2, 4'd3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("pre_rst", c, {s11[11 - c], 1'b1, (c == 4), 1'b1, 1'b0});
    end
    #2 rst = 1'b1;
    #1 chk("rst_midgap", 0, 5'b00000);
    @(negedge clk); chk("rst_held", 0, 5'b00000);
    rst = 1'b0;
    kick(8'b0000_1011, 4'd4, 8'd1, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("post_rst", c, {s4[4 - c], 1'b1, (c == 4), 1'b1, 1'b0});
    end
    @(negedge clk); chk("post_rst_done", 5, 5'b00011);
    @(negedge clk); chk("post_rst_idle", 6, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_generator.md
Name: seq_pattern_generator

Overview:
- Serial bit-pattern transmitter. It is the stimulus source for the team's serial sequence detectors (e.g. overlapping/non-overlapping 1011 Moore/Mealy detectors).
- Loads a pattern word, length, repeat count and inter-repetition gap, then shifts the pattern out MSB-first, one bit per clock.
- Drives a `last_bit` marker on the final bit of each repetition, so a bench can predict detector pulses cycle-accurately.

Parameters:
- PAT_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of `pat_len`; must hold PAT_W, i.e. ≥ clog2(PAT_W+1).
- REP_W, 8, width of the repeat counter.
- GAP_W, 4, width of the gap length.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin; sampled only in IDLE.
- abort  input  1  synchronous cancel of an active transfer.
- pattern  input  PAT_W  pattern bits; transmission starts at `pattern[pat_len-1]`.
- pat_len  input  LEN_W  number of pattern bits; 0 or >PAT_W is treated as PAT_W.
- reps  input  REP_W  number of repetitions; 0 means none.
- gap  input  GAP_W  number of zero bits inserted between repetitions (not after the last one).
- data  output  1  serial bit stream.
- valid  output  1  `data` carries a stream bit (pattern or gap).
- last_bit  output  1  current `data` is the final bit of a repetition.
- busy  output  1  block is not in IDLE.
- done  output  1  one-cycle pulse at normal completion.

Behaviour:
- States: IDLE, SEND, GAP, DONE. All outputs are decoded from registered state only (Moore).
- Reset (async, any time, including mid-transfer):
  - state = IDLE; all counters and latched config = 0.
  - data = valid = last_bit = busy = done = 0.
- IDLE:
  - On a clock edge with `start`=1: latch `pattern`, effective length L, `reps` and `gap`.
  - If reps = 0, go to DONE. Otherwise go to SEND with bit_idx = L-1 and rep_cnt = reps.
  - While in IDLE all outputs are 0.
- Latency: the first pattern bit appears on `data` in the cycle immediately after the `start` edge.
- SEND:
  - data = pat_q[bit_idx]; valid = 1; last_bit = (bit_idx == 0).
  - Each clock with bit_idx > 0: decrement bit_idx.
  - Each clock with bit_idx = 0:
    - If rep_cnt = 1, go to DONE.
    - Else decrement rep_cnt. If gap_q = 0, stay in SEND and reload bit_idx = L-1 (back-to-back repetition, no bubble). Otherwise go to GAP with gap_cnt = gap_q-1.
- GAP:
  - data = 0; valid = 1; last_bit = 0.
  - When gap_cnt = 0, go to SEND with bit_idx = L-1; else decrement gap_cnt.
  - GAP lasts exactly gap_q cycles.
- DONE:
  - done = 1, busy = 1, valid = 0, data = 0 for exactly one cycle, then IDLE.
- busy = 1 in SEND, GAP and DONE.
- `start` outside IDLE is ignored; input changes while busy have no effect (config was latched).
- `abort`:
  - Sampled in SEND or GAP. Next state is IDLE, done is not pulsed, and outputs are 0 from the next cycle.
  - `abort` has priority over all SEND/GAP transitions. It is ignored in IDLE and DONE.
- `start` and `abort` both high in IDLE: start wins (abort ignored in IDLE).
- Counter wrap: reps = 2^REP_W-1 runs to completion with no wrap. rep_cnt never decrements below 1 in SEND.
- Total cycles from the start edge to the done cycle = reps·L + (reps-1)·gap, with done in the following cycle.

Test Plan:
- pattern=8'b0000_1011, pat_len=4, reps=6, gap=0, start pulse -> data = 1011 repeated for 24 cycles, valid=1 throughout; last_bit high in cycles 4,8,…,24; done high in cycle 25. A chained 1011 overlapping detector pulses 6 times, each one cycle after a last_bit.
- Same pattern, reps=2, gap=3 -> data = 1,0,1,1,0,0,0,1,0,1,1 (11 cycles, valid=1); last_bit in cycles 4 and 11; done in cycle 12; busy low in cycle 13.
- reps=0, start -> cycle 1: done=1, valid=0, data=0; cycle 2: IDLE, busy=0.
- pat_len=0, pattern=8'hA5, reps=1 -> data = 1,0,1,0,0,1,0,1 (8 bits), last_bit on cycle 8, done on cycle 9. Repeat with pat_len=12 -> identical result.
- Mid-transfer control (reps=6 run):
  - abort asserted in cycle 6 -> valid=0 and busy=0 from cycle 7; done never pulses.
  - start pulsed again in cycle 3 -> ignored; the stream is unchanged.
- rst asserted asynchronously mid-GAP (between clock edges) -> all outputs 0 immediately. After release, a new start yields a correct fresh sequence from bit L-1.
